shift_issue_queue: RTL and testbench

SHIFT_ISSUE_QUEUE -- requirements
Module: shift_issue_queue

---
 rtl/shift_issue_queue_pkg.sv | 26 ++
 rtl/shift_issue_queue_decode.sv | 28 ++
 rtl/shift_issue_queue.sv | 110 +++++++++++
 tb/tb_shift_issue_queue.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/shift_issue_queue_pkg.sv
// Shared shift-unit encodings and the queue payload layout; imported by the
// issue queue, its decoder and the downstream shift units.
package shift_issue_queue_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0]    op_a;
    logic [SHAMT_W-1:0] shamt;
    logic [3:0]         alu_op;
  } sq_payload_t;

  function automatic logic [XLEN-1:0] zext_shamt(input logic [SHAMT_W-1:0] s);
    return {{(XLEN-SHAMT_W){1'b0}}, s};
  endfunction

endpackage

// File: rtl/shift_issue_queue_decode.sv
// Combinational shift decoder: funct3/bit30 select the shift kind, i_is_imm
// selects where the 5-bit shift amount comes from.
module shift_decode
  import shift_issue_queue_pkg::*;
(
  input  logic [2:0]         i_funct3,
  input  logic               i_funct7_b5,
  input  logic               i_is_imm,
  input  logic [SHAMT_W-1:0] i_imm_shamt,
  input  logic [SHAMT_W-1:0] i_rs2_shamt,
  output logic [3:0]         o_alu_op,
  output logic [SHAMT_W-1:0] o_shamt,
  output logic               o_illegal
);

  always_comb begin
    o_alu_op  = ALU_NONE;
    o_illegal = 1'b1;
    o_shamt   = i_is_imm ? i_imm_shamt : i_rs2_shamt;
    case ({i_funct3, i_funct7_b5})
      {F3_SLL, 1'b0}: begin o_alu_op = ALU_SLL; o_illegal = 1'b0; end
      {F3_SR,  1'b0}: begin o_alu_op = ALU_SRL; o_illegal = 1'b0; end
      {F3_SR,  1'b1}: begin o_alu_op = ALU_SRA; o_illegal = 1'b0; end
      default:        ;
    endcase
  end

endmodule

// File: rtl/shift_issue_queue.sv
// Circular FIFO of decoded shift operations feeding the shift units.
// Head outputs come straight from storage and read as zero when empty.
module shift_issue_queue
  import shift_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [31:0]              i_rs1_data,
  input  logic [31:0]              i_rs2_data,
  input  logic [31:0]              i_imm,
  input  logic                     i_is_imm,
  input  logic [2:0]               i_funct3,
  input  logic                     i_funct7_b5,
  input  logic [TAG_W-1:0]         i_rd,
  output logic                     o_issue_valid,
  input  logic                     i_issue_ready,
  output logic [31:0]              o_op_a,
  output logic [31:0]              o_op_b,
  output logic [3:0]               o_alu_op,
  output logic [TAG_W-1:0]         o_rd,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             illegal_q, illegal_d;

  sq_payload_t      pay_mem [DEPTH];
  logic [TAG_W-1:0] rd_mem  [DEPTH];

  logic [3:0]         dec_alu_op;
  logic [SHAMT_W-1:0] dec_shamt;
  logic               dec_illegal;
  logic               accept, push, pop;

  // Only the shamt field of the immediate / rs2 is meaningful to a shift.
  logic unused_bits;
  assign unused_bits = ^{i_imm[31:SHAMT_W], i_rs2_data[31:SHAMT_W]};

  shift_decode u_decode (
    .i_funct3    (i_funct3),
    .i_funct7_b5 (i_funct7_b5),
    .i_is_imm    (i_is_imm),
    .i_imm_shamt (i_imm[SHAMT_W-1:0]),
    .i_rs2_shamt (i_rs2_data[SHAMT_W-1:0]),
    .o_alu_op    (dec_alu_op),
    .o_shamt     (dec_shamt),
    .o_illegal   (dec_illegal)
  );

  assign o_req_ready   = (count_q < FULL_CNT) && !i_reset;
  assign o_issue_valid = (count_q != '0) && !i_reset;
  assign o_count       = count_q;
  assign o_illegal     = illegal_q && !i_reset;

  assign o_op_a   = o_issue_valid ? pay_mem[head_q].op_a : '0;
  assign o_op_b   = o_issue_valid ? zext_shamt(pay_mem[head_q].shamt) : '0;
  assign o_alu_op = o_issue_valid ? pay_mem[head_q].alu_op : '0;
  assign o_rd     = o_issue_valid ? rd_mem[head_q] : '0;

  always_comb begin
    accept    = i_req_valid && o_req_ready;
    push      = accept && !dec_illegal;
    pop       = o_issue_valid && i_issue_ready;
    illegal_d = accept && dec_illegal;
    // Power-of-two depth lets the pointers wrap by plain overflow.
    tail_d    = push ? tail_q + PTR_W'(1) : tail_q;
    head_d    = pop  ? head_q + PTR_W'(1) : head_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge i_clk) begin
    if (push) begin
      pay_mem[tail_q] <= '{op_a: i_rs1_data, shamt: dec_shamt, alu_op: dec_alu_op};
      rd_mem[tail_q]  <= i_rd;
    end
  end

endmodule

// File: tb/tb_shift_issue_queue.sv
// Randomised and directed bench for shift_issue_queue against a queue-based
// reference model.
module tb_shift_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_rs1_data, i_rs2_data, i_imm;
  logic        i_is_imm;
  logic [2:0]  i_funct3;
  logic        i_funct7_b5;
  logic [TAG_W-1:0] i_rd;
  logic        o_issue_valid;
  logic        i_issue_ready;
  logic [31:0] o_op_a, o_op_b;
  logic [3:0]  o_alu_op;
  logic [TAG_W-1:0] o_rd;
  logic [2:0]  o_count;
  logic        o_illegal;

  shift_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm), .i_is_imm(i_is_imm),
    .i_funct3(i_funct3), .i_funct7_b5(i_funct7_b5), .i_rd(i_rd),
    .o_issue_valid(o_issue_valid), .i_issue_ready(i_issue_ready),
    .o_op_a(o_op_a), .o_op_b(o_op_b), .o_alu_op(o_alu_op), .o_rd(o_rd),
    .o_count(o_count), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
  } ent_t;

  ent_t q[$];
  bit   ill_exp;
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Decode straight from the instruction table: SLL, SRL, SRA, else illegal.
  function automatic bit model_legal(input logic [2:0] f3, input logic b5, output logic [3:0] op);
    op = 4'd0;
    if (f3 == 3'b001 && !b5) begin op = 4'b0001; return 1; end
    if (f3 == 3'b101) begin op = b5 ? 4'b1001 : 4'b1000; return 1; end
    return 0;
  endfunction

  task automatic check_all();
    check("count", 64'(o_count), 64'(q.size()));
    check("req_ready", 64'(o_req_ready), 64'(q.size() < DEPTH));
    check("issue_valid", 64'(o_issue_valid), 64'(q.size() != 0));
    check("illegal", 64'(o_illegal), 64'(ill_exp));
    if (q.size() != 0) begin
      check("op_a", 64'(o_op_a), 64'(q[0].a));
      check("op_b", 64'(o_op_b), 64'(q[0].b));
      check("alu_op", 64'(o_alu_op), 64'(q[0].op));
      check("rd", 64'(o_rd), 64'(q[0].rd));
    end else begin
      check("empty_head", {o_op_a, o_op_b}, 64'd0);
      check("empty_tags", 64'({o_alu_op, o_rd}), 64'd0);
    end
    $display("vec %0d: cnt=%0d valid=%0b rd=%0d op=%0h b=%0d ill=%0b",
             n_vec, o_count, o_issue_valid, o_rd, o_alu_op, o_op_b, o_illegal);
  endtask

  // One clock: drive request, model the edge, compare just after it.
  task automatic cycle(input bit v, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input bit is_imm, input logic [2:0] f3,
                       input bit b5, input logic [4:0] rd, input bit ir);
    logic [3:0] op;
    bit legal, acc, pop;
    ent_t e;
    i_req_valid = v; i_rs1_data = rs1; i_rs2_data = rs2; i_imm = imm;
    i_is_imm = is_imm; i_funct3 = f3; i_funct7_b5 = b5; i_rd = rd; i_issue_ready = ir;
    legal = model_legal(f3, b5, op);
    acc   = v && (q.size() < DEPTH);
    pop   = (q.size() != 0) && ir;
    @(posedge i_clk);
    if (pop) void'(q.pop_front());
    if (acc && legal) begin
      e.a = rs1; e.b = {27'd0, (is_imm ? imm[4:0] : rs2[4:0])}; e.op = op; e.rd = rd;
      q.push_back(e);
    end
    ill_exp = acc && !legal;
    #1;
    check_all();
  endtask

  task automatic idle(input bit ir);
    cycle(0, 32'd0, 32'd0, 32'd0, 0, 3'b000, 0, 5'd0, ir);
  endtask

  initial begin
    i_reset = 1'b1; i_req_valid = 0; i_rs1_data = 0; i_rs2_data = 0; i_imm = 0;
    i_is_imm = 0; i_funct3 = 0; i_funct7_b5 = 0; i_rd = 0; i_issue_ready = 0;
    ill_exp = 0;
    #2;
    check("rst_ready", 64'(o_req_ready), 64'd0);
    check("rst_valid", 64'(o_issue_valid), 64'd0);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_illegal", 64'(o_illegal), 64'd0);
    check("rst_head", {o_op_a, o_op_b}, 64'd0);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_reset = 1'b0;
    #1;
    check("post_rst_ready", 64'(o_req_ready), 64'd1);

    // SRAI of the sign bit by 4.
    cycle(1, 32'h8000_0000, 32'd0, 32'd4, 1, 3'b101, 1, 5'd7, 0);
    check("srai_op", 64'(o_alu_op), 64'h9);
    check("srai_b", 64'(o_op_b), 64'd4);
    check("srai_a", 64'(o_op_a), 64'h8000_0000);
    idle(1);

    // Fill to full, a fifth request must be held off.
    for (int i = 0; i < 4; i++)
      cycle(1, 32'h100 + i, 32'(i), 32'd0, 0, 3'b001, 0, 5'(10 + i), 0);
    check("full_count", 64'(o_count), 64'd4);
    check("full_ready", 64'(o_req_ready), 64'd0);
    cycle(1, 32'hDEAD, 32'd1, 32'd0, 0, 3'b001, 0, 5'd30, 0);
    check("held_count", 64'(o_count), 64'd4);
    idle(1);
    check("pop_count", 64'(o_count), 64'd3);
    check("pop_head", 64'(o_rd), 64'd11);
    idle(0);
    check("pop_ready", 64'(o_req_ready), 64'd1);
    for (int i = 0; i < 3; i++) idle(1);

    // Illegal SLL with bit30 set.
    cycle(1, 32'h55, 32'd2, 32'd0, 0, 3'b001, 1, 5'd3, 0);
    check("illegal_pulse", 64'(o_illegal), 64'd1);
    check("illegal_count", 64'(o_count), 64'd0);
    idle(1);
    check("illegal_clear", 64'(o_illegal), 64'd0);
    check("illegal_noissue", 64'(o_issue_valid), 64'd0);

    // Streaming across the pointer wrap with a register shamt of 3.
    for (int i = 0; i < 10; i++) begin
      cycle(1, 32'(i * 7), 32'hFFFF_FFE3, 32'd9, 0, 3'b101, 0, 5'(i), 1);
      if (o_issue_valid) check("stream_b", 64'(o_op_b), 64'd3);
    end
    for (int i = 0; i < 3; i++) idle(1);

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++)
      cycle(1, 32'(i), 32'd5, 32'd0, 0, 3'b001, 0, 5'(20 + i), 0);
    i_req_valid = 0;
    i_reset = 1'b1;
    #1;
    q.delete(); ill_exp = 0;
    check("async_valid", 64'(o_issue_valid), 64'd0);
    check("async_count", 64'(o_count), 64'd0);
    check("async_ready", 64'(o_req_ready), 64'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    for (int i = 0; i < 3; i++) idle(1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] f3;
      case ($urandom_range(0, 3))
        0: f3 = 3'b001;
        1, 2: f3 = 3'b101;
        default: f3 = 3'($urandom);
      endcase
      cycle($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom, 1'($urandom),
            f3, 1'($urandom), 5'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
